// File: rtl/uart_fifo.sv
// uart_fifo: FIFO-buffered UART with parity, 1/2 stop bits, RX error flags and level irq
// on a four-word single-cycle-ack register window (DATA, STATUS, CTRL, DIV).
module uart_fifo #(
   parameter int FIFO_DEPTH = 8,
   parameter int DIV_WIDTH  = 16,
   parameter int DIV_RESET  = 24
) (
   input  logic        clk,
   input  logic        rst_ni,
   input  logic [1:0]  adr_i,
   input  logic [31:0] dat_i,
   input  logic [3:0]  sel_i,
   input  logic        we_i,
   input  logic        stb_i,
   output logic        ack_o,
   output logic [31:0] dat_o,
   output logic        irq_o,
   input  logic        rxd,
   output logic        txd
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;
   state_t tx_state, tx_next, rx_state, rx_next;
   logic [4:0] ctrl;
   logic [DIV_WIDTH-1:0] div, tx_tmr, rx_tmr;
   logic [31:0] div_w, status;
   logic overrun, frame_err, parity_err;
   logic [7:0] tx_mem [FIFO_DEPTH];
   logic [7:0] rx_mem [FIFO_DEPTH];
   logic [AW-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
   logic [AW:0] tx_cnt, rx_cnt;
   logic wr, rd, clr, tx_push, tx_pop, tx_full, tx_idle, tx_tick;
   logic rx_push, rx_wr, rx_pop, rx_full, rx_avail, rx_samp, rx_perr;
   logic [7:0] tx_sh, tx_sh_n, rx_sh;
   logic [2:0] tx_bit, tx_bit_n, rx_bit;
   logic tx_pen, tx_two, tx_pbit, txd_n, rx_s1, rx_s2, rx_pbit;
   assign ack_o = stb_i;
   assign wr = stb_i & we_i;
   assign rd = stb_i & ~we_i;
   assign clr = wr && adr_i == 2'd1 && sel_i[0];
   assign tx_full = tx_cnt == FULL;
   assign rx_full = rx_cnt == FULL;
   assign rx_avail = rx_cnt != '0;
   assign tx_pop = tx_state == S_IDLE && tx_cnt != '0;
   assign tx_push = wr && adr_i == 2'd0 && sel_i[0] && !tx_full;
   assign tx_idle = tx_cnt == '0 && tx_state == S_IDLE;
   assign tx_tick = tx_tmr >= div;
   assign rx_samp = rx_tmr == (div >> 1);
   assign rx_push = rx_state == S_STOP && rx_samp;
   assign rx_wr = rx_push && !rx_full;
   assign rx_pop = rd && adr_i == 2'd0 && rx_avail;
   assign rx_perr = (^ctrl[1:0]) && ((^{rx_sh, rx_pbit}) != ctrl[1]);
   assign status = {16'b0, 8'(rx_cnt), 1'b0, parity_err, frame_err, overrun, rx_full, rx_avail, tx_full, tx_idle};
   assign irq_o = (ctrl[3] & (rx_avail | overrun | frame_err | parity_err)) | (ctrl[4] & tx_idle);
   always_comb begin
      div_w = 32'(div);
      for (int b = 0; b < 4; b++) if (sel_i[b]) div_w[8*b +: 8] = dat_i[8*b +: 8];
   end
   always_comb begin
      tx_next = tx_state;
      tx_sh_n = tx_sh;
      tx_bit_n = tx_bit;
      case (tx_state)
         S_IDLE: if (tx_cnt != '0) begin tx_next = S_START; tx_sh_n = tx_mem[tx_rp]; end
         S_START: if (tx_tick) begin tx_next = S_DATA; tx_bit_n = 3'd0; end
         S_DATA: if (tx_tick) begin
            tx_sh_n = {1'b0, tx_sh[7:1]};
            tx_bit_n = tx_bit + 3'd1;
            if (tx_bit == 3'd7) tx_next = tx_pen ? S_PAR : S_STOP;
         end
         S_PAR: if (tx_tick) tx_next = S_STOP;
         S_STOP: if (tx_tick) begin
            if (tx_two && tx_bit == 3'd0) tx_bit_n = 3'd1;
            else tx_next = S_IDLE;
         end
         default: tx_next = S_IDLE;
      endcase
      txd_n = tx_next == S_START ? 1'b0 : tx_next == S_DATA ? tx_sh_n[0] : tx_next == S_PAR ? tx_pbit : 1'b1;
   end
   // txd is registered from the next state so the pin never glitches on state decode
   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         tx_state <= S_IDLE;
         tx_tmr <= '0;
         tx_sh <= '0;
         tx_bit <= '0;
         tx_pen <= 1'b0;
         tx_two <= 1'b0;
         tx_pbit <= 1'b0;
         txd <= 1'b1;
      end else begin
         tx_state <= tx_next;
         tx_tmr <= (tx_state == S_IDLE || tx_tick) ? '0 : tx_tmr + 1'b1;
         tx_sh <= tx_sh_n;
         tx_bit <= tx_bit_n;
         txd <= txd_n;
         if (tx_pop) begin
            tx_pen <= ^ctrl[1:0];
            tx_two <= ctrl[2];
            tx_pbit <= ^tx_mem[tx_rp] ^ ctrl[1];
         end
      end
   end
   always_comb begin
      rx_next = rx_state;
      case (rx_state)
         S_IDLE: if (!rx_s2) rx_next = S_START;
         S_START: if (rx_samp) rx_next = rx_s2 ? S_IDLE : S_DATA;
         S_DATA: if (rx_samp && rx_bit == 3'd7) rx_next = (^ctrl[1:0]) ? S_PAR : S_STOP;
         S_PAR: if (rx_samp) rx_next = S_STOP;
         S_STOP: if (rx_samp) rx_next = S_IDLE;
         default: rx_next = S_IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         rx_s1 <= 1'b1;
         rx_s2 <= 1'b1;
         rx_state <= S_IDLE;
         rx_tmr <= '0;
         rx_sh <= '0;
         rx_bit <= '0;
         rx_pbit <= 1'b0;
      end else begin
         rx_s1 <= rxd;
         rx_s2 <= rx_s1;
         rx_state <= rx_next;
         rx_tmr <= (rx_state == S_IDLE || rx_tmr >= div) ? '0 : rx_tmr + 1'b1;
         rx_bit <= rx_state == S_START ? 3'd0 : (rx_samp && rx_state == S_DATA) ? rx_bit + 3'd1 : rx_bit;
         if (rx_samp && rx_state == S_DATA) rx_sh <= {rx_s2, rx_sh[7:1]};
         if (rx_samp && rx_state == S_PAR) rx_pbit <= rx_s2;
      end
   end
   always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wp] <= dat_i[7:0];
      if (rx_wr) rx_mem[rx_wp] <= rx_sh;
   end
   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         tx_wp <= '0;
         tx_rp <= '0;
         tx_cnt <= '0;
         rx_wp <= '0;
         rx_rp <= '0;
         rx_cnt <= '0;
         overrun <= 1'b0;
         frame_err <= 1'b0;
         parity_err <= 1'b0;
         ctrl <= '0;
         div <= DIV_WIDTH'(DIV_RESET);
         dat_o <= '0;
      end else begin
         tx_wp <= tx_wp + {{(AW-1){1'b0}}, tx_push};
         tx_rp <= tx_rp + {{(AW-1){1'b0}}, tx_pop};
         tx_cnt <= tx_cnt + {{AW{1'b0}}, tx_push} - {{AW{1'b0}}, tx_pop};
         rx_wp <= rx_wp + {{(AW-1){1'b0}}, rx_wr};
         rx_rp <= rx_rp + {{(AW-1){1'b0}}, rx_pop};
         rx_cnt <= rx_cnt + {{AW{1'b0}}, rx_wr} - {{AW{1'b0}}, rx_pop};
         overrun <= (rx_push & rx_full) | (overrun & ~(clr & dat_i[4]));
         frame_err <= (rx_push & ~rx_s2) | (frame_err & ~(clr & dat_i[5]));
         parity_err <= (rx_push & rx_perr) | (parity_err & ~(clr & dat_i[6]));
         if (wr && adr_i == 2'd2 && sel_i[0]) ctrl <= dat_i[4:0];
         if (wr && adr_i == 2'd3) div <= DIV_WIDTH'(div_w);
         if (rd) dat_o <= adr_i == 2'd0 ? {24'b0, rx_avail ? rx_mem[rx_rp] : 8'h00} :
                          adr_i == 2'd1 ? status : adr_i == 2'd2 ? {27'b0, ctrl} : 32'(div);
      end
   end
endmodule

// File: doc/uart_fifo.md
# uart_fifo

Parametrised, FIFO-buffered UART peripheral on the single-cycle-ack register bus used by the CPU's other peripherals. It adds TX/RX FIFOs, runtime-selectable parity and stop bits, RX error flags and a level interrupt to the basic divider-timed 8-bit serial transmitter/receiver. It sits on the CPU data bus as a four-word register window and drives the board serial pins.

## Interface
- FIFO_DEPTH, 8: entries per FIFO; power of two, ≥2.
- DIV_WIDTH, 16: width of the bit-period divider register.
- DIV_RESET, 24: divider reset value; bit period = DIV+1 clocks.
- clk  in  1  system clock; all logic rises on it.
- rst_ni  in  1  asynchronous, active-low reset.
- adr_i  in  2  word select: 0 DATA, 1 STATUS, 2 CTRL, 3 DIV.
- dat_i  in  32  write data.
- sel_i  in  4  byte enables, writes only.
- we_i  in  1  1 = write, 0 = read.
- stb_i  in  1  access strobe.
- ack_o  out  1  = stb_i (combinational).
- dat_o  out  32  registered read data.
- irq_o  out  1  level interrupt.
- rxd  in  1  serial input, asynchronous.
- txd  out  1  serial output, idle high.

## Operation
- Registers:
  - DATA write with sel_i[0]: push dat_i[7:0] to TX FIFO; dropped silently if TX full. DATA read: dat_o = {24'b0, RX head}, pop; if RX empty, dat_o = 0, no pop.
  - STATUS read: [0] tx_idle (TX FIFO empty and shifter IDLE), [1] tx_full, [2] rx_avail, [3] rx_full, [4] overrun, [5] frame_err, [6] parity_err, [15:8] RX count, others 0. STATUS write: 1 in bits [6:4] (sel_i[0]) clears that flag; other bits ignored.
  - CTRL [4:0], written under sel_i[0]: [1:0] parity (00 none, 01 even, 10 odd, 11 none), [2] two stop bits, [3] rx_ie, [4] tx_ie. Reset 0.
  - DIV: byte-enabled write, low DIV_WIDTH bits kept; reads zero-extended.
- TX FSM IDLE→START→DATA(8, LSB first)→PARITY (if enabled)→STOP (1 or 2)→IDLE. Each bit lasts DIV+1 clocks. IDLE pops TX FIFO when non-empty and enters START the same edge. CTRL sampled at pop for whole frame.
- RX: rxd through two-flop synchroniser. IDLE→START on synchronised low; counter restarts. Sample at count DIV>>1 of each bit. START sample high → IDLE (glitch, no flags). DATA 8 samples, PARITY check if enabled, one STOP sample (second stop bit not checked). After stop sample: push byte; stop low sets frame_err, parity mismatch sets parity_err; byte still pushed. Push when RX full: byte dropped, overrun set. Return to IDLE immediately after stop sample.
- irq_o = (rx_ie & (rx_avail | overrun | frame_err | parity_err)) | (tx_ie & tx_idle).
- Error flags sticky until write-1-clear; set beats clear in same cycle.

## Timing
- Reset: txd=1, dat_o=0, irq_o=0, FIFOs empty, flags 0, CTRL 0, DIV=DIV_RESET, both FSMs IDLE.
- ack_o same cycle as stb_i; dat_o valid from the next clock edge, held until next read.
- TX: DATA write at edge N → FIFO non-empty after N → pop and txd low after edge N+1 (empty, idle). Frame length 10/11/12 bit periods.
- RX latency: stop-bit sample + 1 edge to rx_avail.
- Simultaneous pop/push: TX — write while full is dropped even if shifter pops that cycle; RX — push while full overruns even if bus pops that cycle. Non-full simultaneous push/pop leaves count unchanged.
- Bit counter ends bit when count ≥ DIV; DIV written mid-frame takes effect immediately, no stuck counter.
- FIFO pointers log2(FIFO_DEPTH) bits, wrap modulo depth; count is one bit wider.
- Reset mid-frame: txd forced 1 immediately (async); partial RX byte discarded.

## Test plan
- Reset, DIV=3, CTRL=0, write DATA=0x55 → txd: 0, 1,0,1,0,1,0,1,0, 1 each 4 clocks; tx_idle returns 1.
- Write FIFO_DEPTH+1 bytes back-to-back while TX idle → first sends, tx_full set at depth, final byte dropped; all accepted bytes emitted in order.
- Loop txd→rxd, CTRL=odd parity + 2 stop, send 0xA3 → rx_avail=1, DATA read 0x000000A3, no error flags.
- Drive rxd frame with even-parity error then stop bit low → parity_err=1, frame_err=1, byte pushed; write STATUS 0x70 clears both.
- Receive FIFO_DEPTH+1 frames without reading → rx_full, overrun=1, first FIFO_DEPTH bytes read back intact; read of empty FIFO returns 0.
- 1-clock low pulse on rxd → no push, no flags; rx_ie=1 with byte received → irq_o=1 until popped.
